reg_file_wb_sb: RTL and testbench
=================================

Name: reg_file_wb_sb

Overview:
Parametrised register-file block for the RV32I core. It merges the read-address gating and write-back source select into the architectural register array, and adds same-cycle write-to-read bypass and a load-pending scoreboard. It sits between decode (read ports), the execute/memory stages (write-back sources) and the control unit, which consumes HAZARD to stall issue.

Parameters:
XLEN, 32, data width of every register and write-back source
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
NUM_READ, 2, number of read ports (1..4)
BYPASS, 1, 1 = a write-back in this cycle is forwarded to matching reads; 0 = reads return the stored array value only

Ports:
CLK  in  1  clock; all state updates on rising edge
RSTN  in  1  reset, asynchronous, active-low
RD_EN  in  NUM_READ  per-port read enable; 0 forces that port to address 0 (x0)
RD_ADDR  in  NUM_READ*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
RD_DATA  out  NUM_READ*XLEN  packed read data, combinational
WB_EN  in  1  write-back enable
WB_ADDR  in  ADDR_W  write-back destination
WB_SEL  in  2  write-back source, type wb_sel_e
ALU_RESULT  in  XLEN  source WB_ALU
MEM_DATA  in  XLEN  source WB_MEM
PC_PLUS4  in  XLEN  source WB_PC4 (link value for JAL/JALR)
IMM  in  XLEN  source WB_IMM (LUI)
PEND_SET  in  1  a load to PEND_ADDR has issued and its data is outstanding
PEND_ADDR  in  ADDR_W  load destination
HAZARD  out  1  some enabled read port targets a pending register

Behaviour:
- Reset (RSTN low, asynchronous): every register = 0 and every pending bit = 0. Hence RD_DATA = 0 and HAZARD = 0 while in reset. Release is synchronous to CLK.
- Effective read address: eff_i = RD_EN[i] ? RD_ADDR_i : 0.
- Write data: wb_data = mux(WB_SEL) of ALU_RESULT / MEM_DATA / PC_PLUS4 / IMM. Codes: 0 ALU, 1 MEM, 2 PC4, 3 IMM. Purely combinational.
- Write: on a rising edge with WB_EN = 1 and WB_ADDR != 0, reg[WB_ADDR] <= wb_data. Writes to x0 are discarded. Latency is 1 cycle to the array.
- Read: RD_DATA_i = 0 if eff_i == 0.
  - Otherwise, if BYPASS and WB_EN and WB_ADDR == eff_i, RD_DATA_i = wb_data (write-first).
  - Otherwise RD_DATA_i = reg[eff_i].
- Scoreboard, one pending bit per register; bit 0 is hardwired to 0.
  - Set: on an edge with PEND_SET = 1 and PEND_ADDR != 0.
  - Clear: on an edge with WB_EN = 1 and WB_SEL == WB_MEM for WB_ADDR.
  - Set and clear of the same address in the same edge: set wins, because a new load supersedes the old one.
  - A non-MEM write-back to a pending register does not clear its bit.
- HAZARD: OR over i of (RD_EN[i] and pend[eff_i]), excluding a port that is satisfied this cycle. A port is satisfied when BYPASS = 1 and a MEM write-back to eff_i is occurring in the same cycle. Combinational, no registered delay.
- All read ports are independent. Any number of ports may share an address.

Decomposition:
- Package rf_pkg:
  - typedef enum logic [1:0] wb_sel_e {WB_ALU, WB_MEM, WB_PC4, WB_IMM}
  - localparam defaults XLEN_DEF = 32 and ADDR_W_DEF = 5
- One natural sub-module, reg_file_scoreboard. It holds the pending-bit vector with set/clear priority and produces a per-address pending lookup. The top instantiates it once; the array, write mux and bypass stay in the top.

Test Plan:
- Reset then read: RSTN low, then release; RD_EN = 2'b11, addresses 5 and 31 -> RD_DATA = 0 on both ports, HAZARD = 0.
- Write and mux: WB_EN = 1, WB_ADDR = 3, WB_SEL = WB_PC4, PC_PLUS4 = 0x0000_1004; next cycle read addr 3 with WB_EN = 0 -> 0x0000_1004. Repeat for each WB_SEL with distinct source values.
- x0 and gating:
  - write 0xDEAD_BEEF to x0 -> reading x0 returns 0;
  - write 0x11 to x7, then RD_EN[0] = 0 with RD_ADDR_0 = 7 -> port 0 = 0, port 1 reading 7 = 0x11.
- Bypass:
  - BYPASS = 1, in the same cycle write ALU_RESULT = 0xA5A5_0001 to x9 while reading x9 -> RD_DATA = 0xA5A5_0001;
  - BYPASS = 0 build -> old value, with the new value visible the next cycle.
- Scoreboard:
  - PEND_SET for x12; next cycle read x12 -> HAZARD = 1;
  - MEM write-back to x12 with data 0x77 in the same cycle -> HAZARD = 0 (BYPASS = 1) and RD_DATA = 0x77;
  - same-edge PEND_SET and MEM write-back to x12 -> bit stays set.
- Async reset mid-operation: pend x4 set and x4 = 0x55; drop RSTN between edges -> HAZARD and RD_DATA fall to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and default widths for the RV32I register-file block.
// The write-back source codes must match the encoding used by the control unit.
package rf_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    localparam int XLEN_DEF   = 32;
    localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/reg_file_wb_sb_if.sv
// Bus bundle between decode/execute/memory stages and the register file.
// The master drives reads, write-backs and load issue; the slave returns data and the hazard flag.
interface reg_file_wb_sb_if
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_READ = 2
);
    logic [NUM_READ-1:0]        RD_EN;
    logic [NUM_READ*ADDR_W-1:0] RD_ADDR;
    logic [NUM_READ*XLEN-1:0]   RD_DATA;
    logic                       WB_EN;
    logic [ADDR_W-1:0]          WB_ADDR;
    wb_sel_e                    WB_SEL;
    logic [XLEN-1:0]            ALU_RESULT;
    logic [XLEN-1:0]            MEM_DATA;
    logic [XLEN-1:0]            PC_PLUS4;
    logic [XLEN-1:0]            IMM;
    logic                       PEND_SET;
    logic [ADDR_W-1:0]          PEND_ADDR;
    logic                       HAZARD;

    modport master (
        output RD_EN, RD_ADDR, WB_EN, WB_ADDR, WB_SEL,
               ALU_RESULT, MEM_DATA, PC_PLUS4, IMM, PEND_SET, PEND_ADDR,
        input  RD_DATA, HAZARD
    );

    modport slave (
        input  RD_EN, RD_ADDR, WB_EN, WB_ADDR, WB_SEL,
               ALU_RESULT, MEM_DATA, PC_PLUS4, IMM, PEND_SET, PEND_ADDR,
        output RD_DATA, HAZARD
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Load-pending scoreboard: one bit per architectural register, x0 never pending.
// A new load to a register overrides a same-edge completion of the older load.
module reg_file_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    output logic [NUM_REGS-1:0] pend
);
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr_en) begin
            pend_d[clr_addr] = 1'b0;
        end
        // Set is applied after clear so it wins on a shared address.
        if (set_en && (set_addr != '0)) begin
            pend_d[set_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/reg_file_wb_sb.sv
// RV32I architectural register file with write-back source select,
// write-first read bypass and load-pending hazard detection.
module reg_file_wb_sb
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1
) (
    input  logic                CLK,
    input  logic                RSTN,
    reg_file_wb_sb_if.slave     bus
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam bit BYPASS_ON = (BYPASS != 0);

    logic [XLEN-1:0]          regs_q [NUM_REGS];
    logic [XLEN-1:0]          regs_d [NUM_REGS];
    logic [XLEN-1:0]          wb_data;
    logic [ADDR_W-1:0]        eff_addr [NUM_READ];
    logic [NUM_READ*XLEN-1:0] rd_data;
    logic                     hazard;
    logic [NUM_REGS-1:0]      pend;
    logic                     mem_wb;

    always_comb begin
        case (bus.WB_SEL)
            WB_ALU:  wb_data = bus.ALU_RESULT;
            WB_MEM:  wb_data = bus.MEM_DATA;
            WB_PC4:  wb_data = bus.PC_PLUS4;
            WB_IMM:  wb_data = bus.IMM;
            default: wb_data = bus.ALU_RESULT;
        endcase
    end

    assign mem_wb = bus.WB_EN && (bus.WB_SEL == WB_MEM);

    always_comb begin
        regs_d = regs_q;
        if (bus.WB_EN && (bus.WB_ADDR != '0)) begin
            regs_d[bus.WB_ADDR] = wb_data;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_file_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (CLK),
        .rst_n    (RSTN),
        .set_en   (bus.PEND_SET),
        .set_addr (bus.PEND_ADDR),
        .clr_en   (mem_wb),
        .clr_addr (bus.WB_ADDR),
        .pend     (pend)
    );

    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            eff_addr[i] = bus.RD_EN[i] ? bus.RD_ADDR[i*ADDR_W +: ADDR_W] : '0;
        end
    end

    // A port whose pending load completes this very cycle is served by the bypass, so it raises no hazard.
    always_comb begin
        rd_data = '0;
        hazard  = 1'b0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (eff_addr[i] == '0) begin
                rd_data[i*XLEN +: XLEN] = '0;
            end else if (BYPASS_ON && bus.WB_EN && (bus.WB_ADDR == eff_addr[i])) begin
                rd_data[i*XLEN +: XLEN] = wb_data;
            end else begin
                rd_data[i*XLEN +: XLEN] = regs_q[eff_addr[i]];
            end
            if (bus.RD_EN[i] && pend[eff_addr[i]]
                && !(BYPASS_ON && mem_wb && (bus.WB_ADDR == eff_addr[i]))) begin
                hazard = 1'b1;
            end
        end
    end

    assign bus.RD_DATA = rd_data;
    assign bus.HAZARD  = hazard;

endmodule

// File: tb/tb_reg_file_wb_sb.sv
// Directed bench for reg_file_wb_sb: one bypassing instance and one non-bypassing
// instance driven by identical stimulus, with hand-computed expectations.
module tb_reg_file_wb_sb;
   import rf_pkg::*;

   localparam int XLEN     = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_READ = 2;

   logic clk;
   logic rstN;
   int   assertCount;
   int   failCount;

   reg_file_wb_sb_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ)) busB ();
   reg_file_wb_sb_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ)) busNb ();

   // The non-bypassing instance mirrors every input of the bypassing one
   assign busNb.RD_EN      = busB.RD_EN;
   assign busNb.RD_ADDR    = busB.RD_ADDR;
   assign busNb.WB_EN      = busB.WB_EN;
   assign busNb.WB_ADDR    = busB.WB_ADDR;
   assign busNb.WB_SEL     = busB.WB_SEL;
   assign busNb.ALU_RESULT = busB.ALU_RESULT;
   assign busNb.MEM_DATA   = busB.MEM_DATA;
   assign busNb.PC_PLUS4   = busB.PC_PLUS4;
   assign busNb.IMM        = busB.IMM;
   assign busNb.PEND_SET   = busB.PEND_SET;
   assign busNb.PEND_ADDR  = busB.PEND_ADDR;

   reg_file_wb_sb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ), .BYPASS(1)) dutB (
      .CLK  (clk),
      .RSTN (rstN),
      .bus  (busB.slave)
   );

   reg_file_wb_sb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ), .BYPASS(0)) dutNb (
      .CLK  (clk),
      .RSTN (rstN),
      .bus  (busNb.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Puts wbVal on the selected source and distinct filler on the others so a wrong mux leg shows up
   task automatic applyStimulus(input logic [1:0] rdEn, input logic [4:0] addr0, input logic [4:0] addr1,
                                input logic wbEn, input logic [4:0] wbAddr, input wb_sel_e wbSel,
                                input logic [31:0] wbVal, input logic pendSet, input logic [4:0] pendAddr);
      busB.RD_EN      = rdEn;
      busB.RD_ADDR    = {addr1, addr0};
      busB.WB_EN      = wbEn;
      busB.WB_ADDR    = wbAddr;
      busB.WB_SEL     = wbSel;
      busB.ALU_RESULT = (wbSel == WB_ALU) ? wbVal : 32'hA1A1_A1A1;
      busB.MEM_DATA   = (wbSel == WB_MEM) ? wbVal : 32'hB2B2_B2B2;
      busB.PC_PLUS4   = (wbSel == WB_PC4) ? wbVal : 32'hC3C3_C3C3;
      busB.IMM        = (wbSel == WB_IMM) ? wbVal : 32'hD4D4_D4D4;
      busB.PEND_SET   = pendSet;
      busB.PEND_ADDR  = pendAddr;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Linear directed sequence; each step drives inputs, lets them settle, then compares
   initial begin
      assertCount = 0;
      failCount   = 0;

      rstN = 1'b0;
      applyStimulus(2'b11, 5'd5, 5'd31, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      #10;
      checkOutput("reset_rd0", busB.RD_DATA[31:0], 32'h0);
      checkOutput("reset_hazard", {31'b0, busB.HAZARD}, 32'h0);
      @(negedge clk);
      rstN = 1'b1;
      tick();
      checkOutput("post_reset_rd0", busB.RD_DATA[31:0], 32'h0);
      checkOutput("post_reset_rd1", busB.RD_DATA[63:32], 32'h0);
      checkOutput("post_reset_hazard", {31'b0, busB.HAZARD}, 32'h0);

      // Each write-back source into its own register, read back the following cycle
      applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd3, WB_PC4, 32'h0000_1004, 1'b0, 5'd0);
      tick();
      applyStimulus(2'b01, 5'd3, 5'd0, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      checkOutput("wb_pc4", busB.RD_DATA[31:0], 32'h0000_1004);
      applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd1, WB_ALU, 32'h1111_0001, 1'b0, 5'd0);
      tick();
      applyStimulus(2'b10, 5'd0, 5'd1, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      checkOutput("wb_alu", busB.RD_DATA[63:32], 32'h1111_0001);
      applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd2, WB_MEM, 32'h2222_0002, 1'b0, 5'd0);
      tick();
      applyStimulus(2'b01, 5'd2, 5'd0, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      checkOutput("wb_mem", busB.RD_DATA[31:0], 32'h2222_0002);
      applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd6, WB_IMM, 32'hABCD_E000, 1'b0, 5'd0);
      tick();
      applyStimulus(2'b11, 5'd6, 5'd3, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      checkOutput("wb_imm", busB.RD_DATA[31:0], 32'hABCD_E000);
      checkOutput("wb_pc4_kept", busB.RD_DATA[63:32], 32'h0000_1004);

      // x0 discards writes; a disabled port reads x0
      applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd0, WB_ALU, 32'hDEAD_BEEF, 1'b0, 5'd0);
      tick();
      applyStimulus(2'b11, 5'd0, 5'd0, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      checkOutput("x0_write_dropped", busB.RD_DATA[31:0], 32'h0);
      applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd7, WB_ALU, 32'h0000_0011, 1'b0, 5'd0);
      tick();
      applyStimulus(2'b10, 5'd7, 5'd7, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      checkOutput("gated_port0", busB.RD_DATA[31:0], 32'h0);
      checkOutput("enabled_port1", busB.RD_DATA[63:32], 32'h0000_0011);

      // Same-cycle write and read of x9
      applyStimulus(2'b01, 5'd9, 5'd0, 1'b1, 5'd9, WB_ALU, 32'hA5A5_0001, 1'b0, 5'd0);
      checkOutput("bypass_on", busB.RD_DATA[31:0], 32'hA5A5_0001);
      checkOutput("bypass_off_old", busNb.RD_DATA[31:0], 32'h0);
      tick();
      applyStimulus(2'b01, 5'd9, 5'd0, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      checkOutput("bypass_off_next", busNb.RD_DATA[31:0], 32'hA5A5_0001);

      // Load to x12 outstanding, then completed by a MEM write-back
      applyStimulus(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b1, 5'd12);
      tick();
      applyStimulus(2'b01, 5'd12, 5'd0, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      checkOutput("pend_hazard", {31'b0, busB.HAZARD}, 32'h1);
      applyStimulus(2'b10, 5'd0, 5'd12, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      checkOutput("pend_port1_hazard", {31'b0, busB.HAZARD}, 32'h1);
      applyStimulus(2'b01, 5'd12, 5'd0, 1'b1, 5'd12, WB_MEM, 32'h0000_0077, 1'b0, 5'd0);
      checkOutput("satisfied_hazard", {31'b0, busB.HAZARD}, 32'h0);
      checkOutput("satisfied_data", busB.RD_DATA[31:0], 32'h0000_0077);
      checkOutput("nobypass_hazard", {31'b0, busNb.HAZARD}, 32'h1);
      tick();
      applyStimulus(2'b01, 5'd12, 5'd0, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      checkOutput("cleared_hazard", {31'b0, busB.HAZARD}, 32'h0);
      checkOutput("cleared_data", busNb.RD_DATA[31:0], 32'h0000_0077);

      // A non-MEM write-back leaves the pending bit alone
      applyStimulus(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b1, 5'd13);
      tick();
      applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd13, WB_ALU, 32'h0000_0005, 1'b0, 5'd0);
      tick();
      applyStimulus(2'b01, 5'd13, 5'd0, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      checkOutput("alu_keeps_pend", {31'b0, busB.HAZARD}, 32'h1);
      checkOutput("alu_keeps_data", busB.RD_DATA[31:0], 32'h0000_0005);

      // New load and old-load completion on the same edge: the bit stays set
      applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd12, WB_MEM, 32'h0000_0088, 1'b1, 5'd12);
      tick();
      applyStimulus(2'b01, 5'd12, 5'd0, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      checkOutput("set_wins_hazard", {31'b0, busB.HAZARD}, 32'h1);
      checkOutput("set_wins_data", busB.RD_DATA[31:0], 32'h0000_0088);

      // Asynchronous reset between edges clears data and pending state at once
      applyStimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd4, WB_ALU, 32'h0000_0055, 1'b1, 5'd4);
      tick();
      applyStimulus(2'b01, 5'd4, 5'd0, 1'b0, 5'd0, WB_ALU, 32'h0, 1'b0, 5'd0);
      checkOutput("pre_areset_hazard", {31'b0, busB.HAZARD}, 32'h1);
      checkOutput("pre_areset_data", busB.RD_DATA[31:0], 32'h0000_0055);
      rstN = 1'b0;
      #1;
      checkOutput("areset_hazard", {31'b0, busB.HAZARD}, 32'h0);
      checkOutput("areset_data", busB.RD_DATA[31:0], 32'h0);
      #10;
      rstN = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
